write_buffer_coalesce: RTL
==========================

Name: write_buffer_coalesce

Overview:
- Parametrised write buffer between the L1 data cache and the next memory level.
- Accepts evicted or written blocks, each with a tag, an index and a data block.
- Drains blocks to memory in FIFO order through a valid/ready handshake.
- Merges a new write into an existing entry with the same address (coalescing) and forwards buffered data to cache read misses (lookup).
- Successor of the fixed 8-entry, 93-bit buffer: adds generic width and depth, full/empty back-pressure, coalescing and lookup.

Parameters:
- TAG_W, 26, tag width in bits.
- IDX_W, 3, index width in bits.
- DATA_W, 64, data block width in bits.
- DEPTH, 8, number of entries; must be a power of two and at least 2.
- COALESCE, 1, 1 enables same-address merge on push; 0 means every push allocates a new entry.

Ports:
- clk  in  1  clock; all state updates on the falling edge of clk.
- reset  in  1  asynchronous, active-high reset.
- push_valid  in  1  a write block is offered.
- push_ready  out  1  the buffer accepts the offered block this cycle.
- push_tag  in  TAG_W  tag of the pushed block.
- push_index  in  IDX_W  index of the pushed block.
- push_data  in  DATA_W  data of the pushed block.
- pop_valid  out  1  the head entry is valid (equals !empty).
- pop_ready  in  1  memory accepts the head entry.
- pop_tag  out  TAG_W  tag of the head entry.
- pop_index  out  IDX_W  index of the head entry.
- pop_data  out  DATA_W  data of the head entry.
- lookup_tag  in  TAG_W  tag of the cache read miss.
- lookup_index  in  IDX_W  index of the cache read miss.
- lookup_hit  out  1  a valid entry matches the lookup address.
- lookup_data  out  DATA_W  data of the youngest matching entry; 0 when there is no hit.
- count  out  $clog2(DEPTH)+1  number of valid entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Storage and pointers:
  - Circular array of DEPTH entries, each with its own valid bit.
  - Write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits, wrap modulo DEPTH.
- Reset (asynchronous, active-high, overrides everything):
  - wr_ptr = 0, rd_ptr = 0, all valid bits = 0, count = 0.
  - Outputs: empty = 1, full = 0, pop_valid = 0, lookup_hit = 0.
  - Entry payloads are cleared to 0, so pop_* and lookup_data read 0.
  - Reset during an active push or pop discards both transfers; no partial update survives.
- Address match:
  - An entry matches when it is valid, its tag equals the offered tag and its index equals the offered index.
- Coalesce hit (COALESCE = 1 only):
  - push matches a valid entry other than the head (the head may already be in flight to memory).
  - On a coalesce hit, that entry's data is overwritten; its pointer, position and count are unchanged.
  - If more than one non-head entry matches, the youngest is written.
- Push acceptance:
  - push_ready = !full || coalesce_hit, combinational from current state and push_tag/push_index.
  - Push fires when push_valid && push_ready. Latency 1: the entry is visible to pop/lookup after the next falling edge.
  - A non-coalescing push writes entry[wr_ptr], sets its valid bit and increments wr_ptr.
  - A push matching only the head allocates a new entry.
- Pop:
  - Pop fires when pop_valid && pop_ready: clears valid[rd_ptr] and increments rd_ptr.
  - pop_* always present entry[rd_ptr] combinationally.
  - pop_ready while empty: no effect.
- Simultaneous events:
  - Push and pop in the same cycle: both take effect; count is unchanged for an allocating push and decrements by 1 for a coalescing push.
  - When full, an allocating push is not accepted even if a pop fires in the same cycle (no pass-through); it is accepted in the following cycle.
  - A coalescing push is never made to the head, so it cannot collide with a pop.
- Lookup:
  - Purely combinational over the current state.
  - Returns the youngest match, scanning from wr_ptr-1 backwards to rd_ptr.
  - A push in the same cycle is not visible to lookup until the next cycle.
- Count: count = valid entries; it always equals the popcount of the valid bits.

Decomposition:
- Package wb_pkg holds:
  - localparams ENTRY_W = TAG_W+IDX_W+DATA_W and PTR_W = $clog2(DEPTH);
  - the entry field offsets;
  - the addr_match function (tag and index compare).
- Sub-module wb_match_cam:
  - Inputs: tag, index, all entries, all valid bits, rd_ptr, wr_ptr.
  - Outputs: hit, one-hot youngest-match vector, and a head-excluded hit flag.
  - Instantiated twice: once for push coalescing, once for lookup.

Test Plan:
- Reset, then 8 allocating pushes (tag = i, index = i, data = 64'h100+i) with pop_ready = 0 -> full = 1, count = 8, push_ready = 0 for a new address, pop_data = 64'h100.
- From the full state, push tag 5 / index 5 / data 64'hBEEF -> push_ready = 1, count stays 8; after popping 5 entries, pop_data = 64'hBEEF.
- Buffer holding one entry (tag 3, index 3), push the same address -> new entry allocated (head match), count = 2; lookup of tag 3 / index 3 returns the younger data.
- Simultaneous push and pop at count = 4 for 20 cycles -> count stays 4, pointers wrap past 7 to 0, pop order matches push order.
- Lookup of an address not in the buffer -> lookup_hit = 0, lookup_data = 0; lookup of tag 2 / index 2 in the same cycle it is pushed -> hit = 0, then hit = 1 next cycle.
- Assert reset mid-burst with push_valid = pop_ready = 1 -> immediately empty = 1, count = 0, pop_valid = 0; the first push after release is popped first with its correct data.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants and helpers for the coalescing write buffer.
package wb_pkg;

  // Default configuration of the buffer.
  localparam int unsigned TAG_W_DEF  = 26;
  localparam int unsigned IDX_W_DEF  = 3;
  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned DEPTH_DEF  = 8;

  // Entry layout for the default configuration: {tag, index, data}.
  localparam int unsigned ENTRY_W  = TAG_W_DEF + IDX_W_DEF + DATA_W_DEF;
  localparam int unsigned PTR_W    = $clog2(DEPTH_DEF);
  localparam int unsigned DATA_LSB = 0;
  localparam int unsigned IDX_LSB  = DATA_W_DEF;
  localparam int unsigned TAG_LSB  = DATA_W_DEF + IDX_W_DEF;

  // Widest tag/index the address compare supports; narrower fields are zero-extended.
  localparam int unsigned MATCH_TAG_W = 64;
  localparam int unsigned MATCH_IDX_W = 32;

  // Address equality: tag and index must both match.
  function automatic logic addr_match(
    input logic [MATCH_TAG_W-1:0] a_tag,
    input logic [MATCH_IDX_W-1:0] a_idx,
    input logic [MATCH_TAG_W-1:0] b_tag,
    input logic [MATCH_IDX_W-1:0] b_idx
  );
    return (a_tag == b_tag) && (a_idx == b_idx);
  endfunction

endpackage

// File: rtl/wb_match_cam.sv
// Associative address search over the buffer entries, reporting the youngest match.
module wb_match_cam
  import wb_pkg::*;
#(
  parameter  int unsigned TAG_W  = 26,
  parameter  int unsigned IDX_W  = 3,
  parameter  int unsigned DATA_W = 64,
  parameter  int unsigned DEPTH  = 8,
  localparam int unsigned E_BITS = TAG_W + IDX_W + DATA_W,
  localparam int unsigned P_BITS = $clog2(DEPTH)
) (
  input  logic [TAG_W-1:0]              tag,
  input  logic [IDX_W-1:0]              index,
  input  logic [DEPTH-1:0][E_BITS-1:0]  entries,
  input  logic [DEPTH-1:0]              valid,
  input  logic [P_BITS-1:0]             rd_ptr,
  input  logic [P_BITS-1:0]             wr_ptr,
  output logic                          hit,
  output logic [DEPTH-1:0]              youngest,
  output logic                          hit_nohead
);

  localparam int unsigned I_OFF = DATA_W;
  localparam int unsigned T_OFF = DATA_W + IDX_W;

  logic [DEPTH-1:0] match;
  logic [DEPTH-1:0] head_oh;

  // Per-entry address compare, qualified by the valid bit.
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid[i] && addr_match(MATCH_TAG_W'(entries[i][T_OFF +: TAG_W]),
                                        MATCH_IDX_W'(entries[i][I_OFF +: IDX_W]),
                                        MATCH_TAG_W'(tag),
                                        MATCH_IDX_W'(index));
    end
  end

  // Scan from the newest slot (wr_ptr-1) back towards the head; first match wins.
  always_comb begin
    logic                found;
    logic [P_BITS-1:0]   pos;
    youngest = '0;
    found    = 1'b0;
    pos      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pos = wr_ptr - P_BITS'(k + 1);
      if (!found && match[pos]) begin
        youngest[pos] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  // The head may already be in flight to memory, so it is excluded for merging.
  always_comb begin
    head_oh    = DEPTH'(1) << rd_ptr;
    hit        = |match;
    hit_nohead = |(match & ~head_oh);
  end

endmodule

// File: rtl/write_buffer_coalesce.sv
// FIFO write buffer between L1 and memory with same-address coalescing and read-miss lookup.
module write_buffer_coalesce
  import wb_pkg::*;
#(
  parameter  int unsigned TAG_W    = 26,
  parameter  int unsigned IDX_W    = 3,
  parameter  int unsigned DATA_W   = 64,
  parameter  int unsigned DEPTH    = 8,
  parameter  int unsigned COALESCE = 1,
  localparam int unsigned P_BITS   = $clog2(DEPTH),
  localparam int unsigned C_BITS   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [TAG_W-1:0]  push_tag,
  input  logic [IDX_W-1:0]  push_index,
  input  logic [DATA_W-1:0] push_data,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [TAG_W-1:0]  pop_tag,
  output logic [IDX_W-1:0]  pop_index,
  output logic [DATA_W-1:0] pop_data,
  input  logic [TAG_W-1:0]  lookup_tag,
  input  logic [IDX_W-1:0]  lookup_index,
  output logic              lookup_hit,
  output logic [DATA_W-1:0] lookup_data,
  output logic [C_BITS-1:0] count,
  output logic              full,
  output logic              empty
);

  localparam int unsigned E_BITS = TAG_W + IDX_W + DATA_W;
  localparam int unsigned I_OFF  = DATA_W;
  localparam int unsigned T_OFF  = DATA_W + IDX_W;

  logic [DEPTH-1:0][E_BITS-1:0] entries_q;
  logic [DEPTH-1:0]             valid_q;
  logic [P_BITS-1:0]            wr_ptr_q;
  logic [P_BITS-1:0]            rd_ptr_q;
  logic [C_BITS-1:0]            count_q;

  logic                         unused_push_hit;
  logic [DEPTH-1:0]             push_young;
  logic                         push_hit_nohead;
  logic                         lk_hit;
  logic [DEPTH-1:0]             lk_young;
  logic                         unused_lk_nohead;

  logic                         coalesce_hit;
  logic                         push_fire;
  logic                         alloc_fire;
  logic                         merge_fire;
  logic                         pop_fire;

  wb_match_cam #(
    .TAG_W  (TAG_W),
    .IDX_W  (IDX_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_push_cam (
    .tag        (push_tag),
    .index      (push_index),
    .entries    (entries_q),
    .valid      (valid_q),
    .rd_ptr     (rd_ptr_q),
    .wr_ptr     (wr_ptr_q),
    .hit        (unused_push_hit),
    .youngest   (push_young),
    .hit_nohead (push_hit_nohead)
  );

  wb_match_cam #(
    .TAG_W  (TAG_W),
    .IDX_W  (IDX_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_lookup_cam (
    .tag        (lookup_tag),
    .index      (lookup_index),
    .entries    (entries_q),
    .valid      (valid_q),
    .rd_ptr     (rd_ptr_q),
    .wr_ptr     (wr_ptr_q),
    .hit        (lk_hit),
    .youngest   (lk_young),
    .hit_nohead (unused_lk_nohead)
  );

  // Handshake decode; a full buffer only accepts merges, never a pass-through allocate.
  always_comb begin
    full         = (count_q == C_BITS'(DEPTH));
    empty        = (count_q == '0);
    coalesce_hit = (COALESCE != 0) && push_hit_nohead;
    push_ready   = !full || coalesce_hit;
    push_fire    = push_valid && push_ready;
    merge_fire   = push_fire && coalesce_hit;
    alloc_fire   = push_fire && !coalesce_hit;
    pop_valid    = !empty;
    pop_fire     = pop_valid && pop_ready;
  end

  // Head entry is presented to memory directly from storage.
  always_comb begin
    pop_tag   = entries_q[rd_ptr_q][T_OFF +: TAG_W];
    pop_index = entries_q[rd_ptr_q][I_OFF +: IDX_W];
    pop_data  = entries_q[rd_ptr_q][DATA_W-1:0];
    count     = count_q;
  end

  // Forward data of the youngest matching entry to a read miss; zero on no hit.
  always_comb begin
    lookup_hit  = lk_hit;
    lookup_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (lk_young[i]) begin
        lookup_data = lookup_data | entries_q[i][DATA_W-1:0];
      end
    end
  end

  // Storage, pointers and occupancy; updated on the falling edge.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      entries_q <= '0;
      valid_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      if (pop_fire) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + P_BITS'(1);
      end
      if (merge_fire) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (push_young[i]) begin
            entries_q[i][DATA_W-1:0] <= push_data;
          end
        end
      end
      if (alloc_fire) begin
        entries_q[wr_ptr_q] <= {push_tag, push_index, push_data};
        valid_q[wr_ptr_q]   <= 1'b1;
        wr_ptr_q            <= wr_ptr_q + P_BITS'(1);
      end
      count_q <= count_q + C_BITS'(alloc_fire) - C_BITS'(pop_fire);
    end
  end

endmodule
